// File: rtl/tm_pkg.sv
// Shared defaults and FSM state encoding for the Tsetlin-machine load/inference controller.
package tm_pkg;

    localparam int unsigned N_EX_DEF   = 12;
    localparam int unsigned EX_W_DEF   = 18;
    localparam int unsigned FEAT_W_DEF = 9;
    localparam int unsigned CLS_W_DEF  = 2;

    localparam int unsigned ST_W = 3;
    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOAD   = 3'd1;
    localparam state_t ST_ACCEPT = 3'd2;
    localparam state_t ST_INFER  = 3'd3;
    localparam state_t ST_HOLD   = 3'd4;

endpackage

// File: rtl/tm_ex_bank.sv
// Clause-exclude register bank: one write port from tm_load_ctrl, one combinational read port.
module tm_ex_bank
    import tm_pkg::*;
#(
    parameter int unsigned N_EX = N_EX_DEF,
    parameter int unsigned EX_W = EX_W_DEF
) (
    input  logic            clk1,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [3:0]      wr_addr,
    input  logic [EX_W-1:0] wr_data,
    input  logic [3:0]      rd_addr,
    output logic [EX_W-1:0] rd_data
);

    logic [EX_W-1:0] mem_q [N_EX];

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_EX; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en && (32'(wr_addr) < N_EX)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if (32'(rd_addr) < N_EX) begin
            rd_data = mem_q[rd_addr];
        end
    end

endmodule

// File: rtl/tm_load_ctrl.sv
// Loads N_EX exclude words into the external bank, then runs feature -> class inference handshakes.
module tm_load_ctrl
    import tm_pkg::*;
#(
    parameter int unsigned N_EX      = N_EX_DEF,
    parameter int unsigned EX_W      = EX_W_DEF,
    parameter int unsigned FEAT_W    = FEAT_W_DEF,
    parameter int unsigned CLS_W     = CLS_W_DEF,
    parameter int unsigned INFER_LAT = 2
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic              ex_in_valid,
    input  logic [EX_W-1:0]   ex_in_data,
    output logic              ex_in_ready,
    output logic              ex_wr_en,
    output logic [3:0]        ex_wr_addr,
    output logic [EX_W-1:0]   ex_wr_data,
    output logic              cfg_done,
    input  logic              feat_valid,
    input  logic [FEAT_W-1:0] feat_data,
    output logic              feat_ready,
    output logic [FEAT_W-1:0] feat_out,
    input  logic [CLS_W-1:0]  infer_class,
    output logic              class_valid,
    output logic [CLS_W-1:0]  class_out,
    input  logic              class_ready
);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        wait_q, wait_d;
    logic              ex_wr_en_q, ex_wr_en_d;
    logic [3:0]        ex_wr_addr_q, ex_wr_addr_d;
    logic [EX_W-1:0]   ex_wr_data_q, ex_wr_data_d;
    logic              cfg_done_q, cfg_done_d;
    logic              class_valid_q, class_valid_d;
    logic [CLS_W-1:0]  class_out_q, class_out_d;
    logic [FEAT_W-1:0] feat_out_q, feat_out_d;
    logic              ex_hs, feat_hs;

    // Readies are masked by cfg_start so a restart never races a beat.
    assign ex_in_ready = (state_q == ST_LOAD) & ~cfg_start;
    assign feat_ready  = (state_q == ST_ACCEPT) & ~cfg_start;
    assign ex_hs       = ex_in_valid & ex_in_ready;
    assign feat_hs     = feat_valid & feat_ready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wait_d        = wait_q;
        ex_wr_en_d    = 1'b0;
        ex_wr_addr_d  = ex_wr_addr_q;
        ex_wr_data_d  = ex_wr_data_q;
        cfg_done_d    = cfg_done_q;
        class_valid_d = class_valid_q;
        class_out_d   = class_out_q;
        feat_out_d    = feat_out_q;

        if (cfg_start) begin
            state_d       = ST_LOAD;
            cnt_d         = '0;
            wait_d        = '0;
            cfg_done_d    = 1'b0;
            class_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (ex_hs) begin
                        ex_wr_en_d   = 1'b1;
                        ex_wr_addr_d = cnt_q;
                        ex_wr_data_d = ex_in_data;
                        cnt_d        = cnt_q + 4'd1;
                        if (cnt_q == 4'(N_EX - 1)) begin
                            state_d    = ST_ACCEPT;
                            cfg_done_d = 1'b1;
                        end
                    end
                end
                ST_ACCEPT: begin
                    if (feat_hs) begin
                        feat_out_d = feat_data;
                        wait_d     = 4'(INFER_LAT);
                        state_d    = ST_INFER;
                    end
                end
                ST_INFER: begin
                    if (wait_q == '0) begin
                        class_out_d   = infer_class;
                        class_valid_d = 1'b1;
                        state_d       = ST_HOLD;
                    end else begin
                        wait_d = wait_q - 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (class_ready) begin
                        class_valid_d = 1'b0;
                        state_d       = ST_ACCEPT;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            wait_q        <= '0;
            ex_wr_en_q    <= 1'b0;
            ex_wr_addr_q  <= '0;
            ex_wr_data_q  <= '0;
            cfg_done_q    <= 1'b0;
            class_valid_q <= 1'b0;
            class_out_q   <= '0;
            feat_out_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wait_q        <= wait_d;
            ex_wr_en_q    <= ex_wr_en_d;
            ex_wr_addr_q  <= ex_wr_addr_d;
            ex_wr_data_q  <= ex_wr_data_d;
            cfg_done_q    <= cfg_done_d;
            class_valid_q <= class_valid_d;
            class_out_q   <= class_out_d;
            feat_out_q    <= feat_out_d;
        end
    end

    assign ex_wr_en    = ex_wr_en_q;
    assign ex_wr_addr  = ex_wr_addr_q;
    assign ex_wr_data  = ex_wr_data_q;
    assign cfg_done    = cfg_done_q;
    assign class_valid = class_valid_q;
    assign class_out   = class_out_q;
    assign feat_out    = feat_out_q;

endmodule

// File: tb/tb_tm_load_ctrl.sv
// Directed-plus-random bench for tm_load_ctrl with the exclude bank attached to its write port.
module tb_tm_load_ctrl;
    import tm_pkg::*;

    localparam int unsigned N  = 12;
    localparam int unsigned EW = 18;
    localparam int unsigned FW = 9;
    localparam int unsigned CW = 2;
    localparam int unsigned L  = 2;

    logic          clk1 = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_start = 1'b0;
    logic          ex_in_valid = 1'b0;
    logic [EW-1:0] ex_in_data = '0;
    logic          ex_in_ready;
    logic          ex_wr_en;
    logic [3:0]    ex_wr_addr;
    logic [EW-1:0] ex_wr_data;
    logic          cfg_done;
    logic          feat_valid = 1'b0;
    logic [FW-1:0] feat_data = '0;
    logic          feat_ready;
    logic [FW-1:0] feat_out;
    logic [CW-1:0] infer_class = '0;
    logic          class_valid;
    logic [CW-1:0] class_out;
    logic          class_ready = 1'b0;
    logic [3:0]    rd_addr = '0;
    logic [EW-1:0] rd_data;

    int unsigned   tests = 0;
    int unsigned   fails = 0;
    logic [EW-1:0] exp_bank [N];

    always #5 clk1 = ~clk1;

    tm_load_ctrl #(
        .N_EX(N), .EX_W(EW), .FEAT_W(FW), .CLS_W(CW), .INFER_LAT(L)
    ) dut (
        .clk1(clk1), .rst_n(rst_n), .cfg_start(cfg_start),
        .ex_in_valid(ex_in_valid), .ex_in_data(ex_in_data), .ex_in_ready(ex_in_ready),
        .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data),
        .cfg_done(cfg_done), .feat_valid(feat_valid), .feat_data(feat_data),
        .feat_ready(feat_ready), .feat_out(feat_out), .infer_class(infer_class),
        .class_valid(class_valid), .class_out(class_out), .class_ready(class_ready)
    );

    tm_ex_bank #(.N_EX(N), .EX_W(EW)) bank (
        .clk1(clk1), .rst_n(rst_n), .wr_en(ex_wr_en), .wr_addr(ex_wr_addr),
        .wr_data(ex_wr_data), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ex_in_ready"}, 32'(ex_in_ready), 0);
        chk({tag, "_feat_ready"},  32'(feat_ready), 0);
        chk({tag, "_ex_wr_en"},    32'(ex_wr_en), 0);
        chk({tag, "_ex_wr_addr"},  32'(ex_wr_addr), 0);
        chk({tag, "_ex_wr_data"},  32'(ex_wr_data), 0);
        chk({tag, "_cfg_done"},    32'(cfg_done), 0);
        chk({tag, "_class_valid"}, 32'(class_valid), 0);
        chk({tag, "_class_out"},   32'(class_out), 0);
        chk({tag, "_feat_out"},    32'(feat_out), 0);
    endtask

    // One-cycle cfg_start pulse; afterwards the controller must be loading.
    task automatic restart(input logic with_valid, input logic with_ready);
        cfg_start   = 1'b1;
        ex_in_valid = with_valid;
        ex_in_data  = EW'($urandom);
        class_ready = with_ready;
        #1;
        chk("start_ex_ready_masked", 32'(ex_in_ready), 0);
        chk("start_feat_ready_masked", 32'(feat_ready), 0);
        tick();
        cfg_start   = 1'b0;
        ex_in_valid = 1'b0;
        class_ready = 1'b0;
        chk("start_no_write", 32'(ex_wr_en), 0);
        chk("start_cfg_done_clr", 32'(cfg_done), 0);
        chk("start_class_valid_clr", 32'(class_valid), 0);
        #1;
        chk("start_in_load", 32'(ex_in_ready), 1);
    endtask

    task automatic do_load(input int unsigned n, input bit seq);
        logic [EW-1:0] w;
        for (int unsigned k = 0; k < n; k++) begin
            w = seq ? EW'(k + 1) : EW'($urandom);
            ex_in_valid = 1'b1;
            ex_in_data  = w;
            #1;
            chk("load_ready", 32'(ex_in_ready), 1);
            tick();
            chk("load_wr_en", 32'(ex_wr_en), 1);
            chk("load_wr_addr", 32'(ex_wr_addr), k);
            chk("load_wr_data", 32'(ex_wr_data), 32'(w));
            chk("load_cfg_done", 32'(cfg_done), 32'(k == N - 1));
            exp_bank[k] = w;
        end
        ex_in_valid = 1'b0;
    endtask

    task automatic finish_load_check();
        ex_in_valid = 1'b1;
        ex_in_data  = EW'(13);
        #1;
        chk("extra_beat_ready", 32'(ex_in_ready), 0);
        tick();
        ex_in_valid = 1'b0;
        chk("extra_beat_no_write", 32'(ex_wr_en), 0);
        chk("loaded_cfg_done", 32'(cfg_done), 1);
        #1;
        chk("loaded_feat_ready", 32'(feat_ready), 1);
    endtask

    task automatic check_bank(input string tag);
        for (int unsigned i = 0; i < N; i++) begin
            rd_addr = 4'(i);
            #1;
            chk(tag, 32'(rd_data), 32'(exp_bank[i]));
        end
        tick();
    endtask

    // Feature handshake, class captured L+1 edges later, then held for 'hold' cycles.
    task automatic do_infer(input logic [FW-1:0] f, input logic [CW-1:0] cls,
                            input int unsigned hold, input bit release_it);
        feat_valid  = 1'b1;
        feat_data   = f;
        infer_class = CW'($urandom);
        #1;
        chk("infer_feat_ready", 32'(feat_ready), 1);
        tick();
        feat_valid = 1'b0;
        feat_data  = FW'($urandom);
        chk("infer_feat_out", 32'(feat_out), 32'(f));
        chk("infer_busy_no_valid", 32'(class_valid), 0);
        chk("infer_busy_feat_ready", 32'(feat_ready), 0);
        for (int unsigned j = 1; j <= L + 1; j++) begin
            infer_class = (j == L + 1) ? cls : CW'($urandom);
            tick();
            if (j <= L) chk("infer_early_valid", 32'(class_valid), 0);
        end
        chk("infer_class_valid", 32'(class_valid), 1);
        chk("infer_class_out", 32'(class_out), 32'(cls));
        chk("infer_feat_out_held", 32'(feat_out), 32'(f));
        for (int unsigned h = 0; h < hold; h++) begin
            infer_class = CW'($urandom);
            tick();
            chk("hold_valid", 32'(class_valid), 1);
            chk("hold_class_out", 32'(class_out), 32'(cls));
            chk("hold_feat_ready", 32'(feat_ready), 0);
        end
        if (release_it) begin
            class_ready = 1'b1;
            tick();
            class_ready = 1'b0;
            chk("release_valid_low", 32'(class_valid), 0);
            chk("release_feat_out", 32'(feat_out), 32'(f));
            #1;
            chk("release_feat_ready", 32'(feat_ready), 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int unsigned i = 0; i < N; i++) exp_bank[i] = '0;

        #2;
        chk_all_zero("reset");
        #6;
        rst_n = 1'b1;
        tick();
        chk_all_zero("idle");
        ex_in_valid = 1'b1;
        feat_valid  = 1'b1;
        tick();
        chk("idle_no_write", 32'(ex_wr_en), 0);
        chk("idle_feat_ready", 32'(feat_ready), 0);
        ex_in_valid = 1'b0;
        feat_valid  = 1'b0;

        // Sequential words 1..12 then an ignored 13th.
        restart(1'b0, 1'b0);
        do_load(N, 1'b1);
        finish_load_check();
        check_bank("bank_seq");

        do_infer(FW'(9'h1A5), CW'(2), 5, 1'b1);
        for (int unsigned r = 0; r < 4; r++) begin
            do_infer(FW'($urandom), CW'($urandom), $urandom_range(0, 5), 1'b1);
        end

        // Abort after six beats; cfg_start also collides with a valid beat.
        restart(1'b0, 1'b0);
        do_load(6, 1'b0);
        restart(1'b1, 1'b0);
        check_bank("bank_partial");
        do_load(N, 1'b0);
        finish_load_check();
        check_bank("bank_reload");

        // cfg_start together with class_ready while holding a result.
        do_infer(FW'($urandom), CW'($urandom), 2, 1'b0);
        restart(1'b0, 1'b1);
        do_load(N, 1'b0);
        finish_load_check();
        do_infer(FW'($urandom), CW'($urandom), 1, 1'b1);

        // Asynchronous reset in the middle of an inference.
        feat_valid = 1'b1;
        feat_data  = FW'($urandom | 1);
        tick();
        feat_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        #1;
        rst_n = 1'b1;
        tick();
        chk_all_zero("post_reset");
        feat_valid = 1'b1;
        tick();
        feat_valid = 1'b0;
        chk("post_reset_feat_ready", 32'(feat_ready), 0);
        chk("post_reset_feat_out", 32'(feat_out), 0);
        for (int unsigned i = 0; i < N; i++) exp_bank[i] = '0;
        check_bank("bank_after_reset");
        restart(1'b0, 1'b0);
        do_load(N, 1'b0);
        finish_load_check();
        do_infer(FW'($urandom), CW'($urandom), 3, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
